// File: rtl/field_insert_packer.sv
// Inserts FIELD_W-bit fields at run-time bit offsets into a WORD_W-bit word.
// Optional FIELD_PACK_AUTOFLUSH_EN: a full mask closes the word without in_last.
module field_insert_packer #(
  parameter int WORD_W  = 16,
  parameter int FIELD_W = 4,
  parameter int OFF_W   = 5,
  parameter logic [WORD_W-1:0] INIT = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OFF_W-1:0]   in_off,
  input  logic [FIELD_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_word,
  output logic [WORD_W-1:0]  out_mask,
  output logic               err_range
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  mask;
  logic               err;
  logic               ready_q;
  logic               valid_q;

  logic               accept;
  logic               oor;
  logic               full;
  logic [WORD_W-1:0]  sel;
  logic [WORD_W-1:0]  shifted;
  logic [WORD_W-1:0]  ins_word;
  logic [WORD_W-1:0]  ins_mask;

  // Shift field and its bit-select into place; bits beyond the word fall off.
  always_comb begin
    accept   = in_valid & ready_q;
    oor      = {1'b0, in_off} >= (OFF_W+1)'(WORD_W);
    sel      = WORD_W'({FIELD_W{1'b1}}) << in_off;
    shifted  = WORD_W'(in_data) << in_off;
    ins_word = (word & ~sel) | (shifted & sel);
    ins_mask = mask | sel;
`ifdef FIELD_PACK_AUTOFLUSH_EN
    full     = &ins_mask;
`else
    full     = 1'b0;
`endif
  end

  // Assembly FSM with registered handshake and error outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      word    <= INIT;
      mask    <= '0;
      err     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE, FILL: begin
          if (accept) begin
            word <= ins_word;
            mask <= ins_mask;
            err  <= oor;
            if (in_last || full) begin
              state   <= EMIT;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state   <= IDLE;
            word    <= INIT;
            mask    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          word    <= INIT;
          mask    <= '0;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_word  = word;
  assign out_mask  = mask;
  assign err_range = err;

endmodule
